// File: rtl/fault_classifier_scheduler.sv
// Round-robin fault classifier: per-port verdict slots feed Healthy/Intermittent/Faulty FSMs, one verdict per cycle.
// Pulse to state/event takes 2 edges; grants stall while an event is held unaccepted, slots keep capturing.
module fault_classifier_scheduler #(
  parameter int PORTS                     = 4,
  parameter int PORT_BITS                 = 2,
  parameter int counter_depth             = 8,
  parameter int healthy_counter_threshold = 4,
  parameter int faulty_counter_threshold  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PORTS-1:0]       faulty_packet,
  input  logic [PORTS-1:0]       healthy_packet,
  input  logic [PORTS-1:0]       clear_port,
  output logic [3*PORTS-1:0]     port_state,
  output logic [PORTS-1:0]       overflow,
  output logic                   event_valid,
  input  logic                   event_ready,
  output logic [PORT_BITS-1:0]   event_port,
  output logic [2:0]             event_state
);

  localparam logic [2:0] ST_H = 3'b001;
  localparam logic [2:0] ST_I = 3'b010;
  localparam logic [2:0] ST_F = 3'b100;
  localparam logic [counter_depth-1:0] FTH     = counter_depth'(faulty_counter_threshold);
  localparam logic [counter_depth-1:0] HTH     = counter_depth'(healthy_counter_threshold);
  localparam logic [counter_depth-1:0] CNT_MAX = '1;

  logic [PORTS-1:0][2:0]               st_q, st_d;
  logic [PORTS-1:0][counter_depth-1:0] fc_q, fc_d, hc_q, hc_d;
  logic [PORTS-1:0]                    slot_full_q, slot_full_d;
  logic [PORTS-1:0]                    slot_faulty_q, slot_faulty_d;
  logic [PORTS-1:0]                    ovf_q, ovf_d;
  logic [PORT_BITS-1:0]                rr_q, rr_d;
  logic                                ev_vld_q, ev_vld_d;
  logic [PORT_BITS-1:0]                ev_port_q, ev_port_d;
  logic [2:0]                          ev_state_q, ev_state_d;

  logic                     stall, gnt_vld, svc_faulty, transition, granted;
  logic [PORT_BITS-1:0]     gnt_port, idx;
  logic [counter_depth-1:0] fc_inc, hc_inc;
  logic [2:0]               cur_st, new_st;

  always_comb begin
    stall      = ev_vld_q & ~event_ready;
    gnt_vld    = 1'b0;
    gnt_port   = '0;
    idx        = '0;
    svc_faulty = 1'b0;
    transition = 1'b0;
    granted    = 1'b0;
    fc_inc     = '0;
    hc_inc     = '0;
    cur_st     = ST_H;
    new_st     = ST_H;

    st_d          = st_q;
    fc_d          = fc_q;
    hc_d          = hc_q;
    slot_full_d   = slot_full_q;
    slot_faulty_d = slot_faulty_q;
    ovf_d         = ovf_q;
    rr_d          = rr_q;
    ev_vld_d      = ev_vld_q & ~event_ready;
    ev_port_d     = ev_port_q;
    ev_state_d    = ev_state_q;

    for (int k = 0; k < PORTS; k++) begin
      idx = rr_q + PORT_BITS'(k);
      if (!gnt_vld && slot_full_q[idx]) begin
        gnt_vld  = 1'b1;
        gnt_port = idx;
      end
    end
    // A clear on the winning port cancels the whole grant so rr stays put.
    if (stall || clear_port[gnt_port]) gnt_vld = 1'b0;

    if (gnt_vld) begin
      rr_d       = gnt_port + PORT_BITS'(1);
      svc_faulty = slot_faulty_q[gnt_port];
      cur_st     = st_q[gnt_port];
      new_st     = cur_st;
      fc_inc     = (fc_q[gnt_port] == CNT_MAX) ? fc_q[gnt_port] : fc_q[gnt_port] + counter_depth'(1);
      hc_inc     = (hc_q[gnt_port] == CNT_MAX) ? hc_q[gnt_port] : hc_q[gnt_port] + counter_depth'(1);
      case (cur_st)
        ST_H, ST_I: begin
          if (svc_faulty) begin
            if (fc_inc == FTH) begin
              fc_d[gnt_port] = '0;
              hc_d[gnt_port] = '0;
              new_st         = (cur_st == ST_H) ? ST_I : ST_F;
              transition     = 1'b1;
            end else begin
              fc_d[gnt_port] = fc_inc;
            end
          end else if (hc_inc == HTH) begin
            fc_d[gnt_port] = '0;
            hc_d[gnt_port] = '0;
            if (cur_st == ST_I) begin
              new_st     = ST_H;
              transition = 1'b1;
            end
          end else begin
            hc_d[gnt_port] = hc_inc;
          end
        end
        ST_F: begin
          fc_d[gnt_port] = '0;
          hc_d[gnt_port] = '0;
        end
        default: begin
          fc_d[gnt_port] = '0;
          hc_d[gnt_port] = '0;
          new_st         = ST_H;
          transition     = 1'b1;
        end
      endcase
      st_d[gnt_port] = new_st;
      if (transition) begin
        ev_vld_d   = 1'b1;
        ev_port_d  = gnt_port;
        ev_state_d = new_st;
      end
    end

    for (int i = 0; i < PORTS; i++) begin
      granted = gnt_vld && (gnt_port == PORT_BITS'(i));
      if (granted) slot_full_d[i] = 1'b0;
      if (faulty_packet[i] || healthy_packet[i]) begin
        if (!slot_full_q[i] || granted) begin
          slot_full_d[i]   = 1'b1;
          slot_faulty_d[i] = faulty_packet[i];
        end else begin
          ovf_d[i] = 1'b1;
        end
      end
      if (faulty_packet[i] && healthy_packet[i]) ovf_d[i] = 1'b1;
      if (clear_port[i]) begin
        slot_full_d[i] = 1'b0;
        ovf_d[i]       = 1'b0;
        st_d[i]        = ST_H;
        fc_d[i]        = '0;
        hc_d[i]        = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q          <= {PORTS{ST_H}};
      fc_q          <= '0;
      hc_q          <= '0;
      slot_full_q   <= '0;
      slot_faulty_q <= '0;
      ovf_q         <= '0;
      rr_q          <= '0;
      ev_vld_q      <= 1'b0;
      ev_port_q     <= '0;
      ev_state_q    <= ST_H;
    end else begin
      st_q          <= st_d;
      fc_q          <= fc_d;
      hc_q          <= hc_d;
      slot_full_q   <= slot_full_d;
      slot_faulty_q <= slot_faulty_d;
      ovf_q         <= ovf_d;
      rr_q          <= rr_d;
      ev_vld_q      <= ev_vld_d;
      ev_port_q     <= ev_port_d;
      ev_state_q    <= ev_state_d;
    end
  end

  assign port_state  = st_q;
  assign overflow    = ovf_q;
  assign event_valid = ev_vld_q;
  assign event_port  = ev_port_q;
  assign event_state = ev_state_q;

endmodule
